// File: rtl/uart_prog_loader.sv
// UART program loader: receives a framed image on rx, writes little-endian words into
// instruction memory, holds the core in reset while loading and answers ACK/NAK on tx.
module uart_prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned WORD_BYTES   = 4,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx,
    output logic                    tx,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    core_rst_n,
    output logic                    busy,
    output logic                    err
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BI_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BI_W-1:0]  LANE_LAST = BI_W'(WORD_BYTES - 1);
    localparam longint unsigned  DEPTH     = 64'd1 << ADDR_W;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
    } rx_state_e;

    typedef enum logic [2:0] {
        LD_IDLE, LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_RESP, LD_WAIT_TX
    } ld_state_e;

    // ------------------------------------------------------------------ RX
    logic rx_meta_q, rx_sync_q;

    // NOTE: sequential state is always updated with non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_valid, frame_err;

    // NOTE: every output of a combinational block is given a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        rx_state_d = RX_BREAK;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            // A low stop bit leaves the line low; wait for idle so it is not taken as a new start.
            RX_BREAK: begin
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // -------------------------------------------------------------- loader
    ld_state_e              ld_state_q, ld_state_d;
    logic [7:0]             len_lo_q, len_lo_d;
    logic [15:0]            len_q, len_d;
    logic [15:0]            word_cnt_q, word_cnt_d;
    logic [BI_W-1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [8*WORD_BYTES-1:0] wdata_q, wdata_d;
    logic                   we_q, we_d;
    logic                   core_rst_n_q, core_rst_n_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic                   ack_q, ack_d;
    logic                   tx_start, tx_done;
    logic [15:0]            len_rx;

    assign len_rx = {rx_shift_q, len_lo_q};

    always_comb begin
        ld_state_d   = ld_state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        byte_idx_d   = byte_idx_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        core_rst_n_d = core_rst_n_q;
        busy_d       = busy_q;
        err_d        = err_q;
        ack_d        = ack_q;
        tx_start     = 1'b0;

        if (we_q) addr_d = addr_q + 1'b1;

        unique case (ld_state_q)
            LD_IDLE: begin
                if (byte_valid && rx_shift_q == SYNC_BYTE) begin
                    core_rst_n_d = 1'b0;
                    busy_d       = 1'b1;
                    err_d        = 1'b0;
                    addr_d       = '0;
                    byte_idx_d   = '0;
                    word_cnt_d   = '0;
                    ld_state_d   = LD_LEN_LO;
                end
            end
            LD_LEN_LO, LD_LEN_HI, LD_DATA: begin
                if (frame_err) begin
                    err_d      = 1'b1;
                    ack_d      = 1'b0;
                    ld_state_d = LD_RESP;
                end else if (byte_valid) begin
                    if (ld_state_q == LD_LEN_LO) begin
                        len_lo_d   = rx_shift_q;
                        ld_state_d = LD_LEN_HI;
                    end else if (ld_state_q == LD_LEN_HI) begin
                        len_d = len_rx;
                        if (len_rx == 16'd0) begin
                            ack_d      = 1'b1;
                            ld_state_d = LD_RESP;
                        end else if (64'(len_rx) > DEPTH) begin
                            err_d      = 1'b1;
                            ack_d      = 1'b0;
                            ld_state_d = LD_RESP;
                        end else begin
                            ld_state_d = LD_DATA;
                        end
                    end else begin
                        for (int i = 0; i < int'(WORD_BYTES); i++) begin
                            if (byte_idx_q == BI_W'(i)) wdata_d[i*8 +: 8] = rx_shift_q;
                        end
                        if (byte_idx_q == LANE_LAST) begin
                            byte_idx_d = '0;
                            we_d       = 1'b1;
                            word_cnt_d = word_cnt_q + 16'd1;
                            if (word_cnt_q == len_q - 16'd1) begin
                                ack_d      = 1'b1;
                                ld_state_d = LD_RESP;
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end
                end
            end
            LD_RESP: begin
                tx_start   = 1'b1;
                ld_state_d = LD_WAIT_TX;
            end
            LD_WAIT_TX: begin
                if (tx_done) begin
                    busy_d     = 1'b0;
                    ld_state_d = LD_IDLE;
                    if (ack_q) core_rst_n_d = 1'b1;
                end
            end
            default: ld_state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state_q   <= LD_IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_idx_q   <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            core_rst_n_q <= 1'b1;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            ld_state_q   <= ld_state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_idx_q   <= byte_idx_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            ack_q        <= ack_d;
        end
    end

    // ------------------------------------------------------------------ TX
    logic             tx_q, tx_d;
    logic             tx_active_q, tx_active_d;
    logic [8:0]       tx_shift_q, tx_shift_d;
    logic [3:0]       tx_bit_q, tx_bit_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;

    always_comb begin
        tx_d        = tx_q;
        tx_active_d = tx_active_q;
        tx_shift_d  = tx_shift_q;
        tx_bit_d    = tx_bit_q;
        tx_cnt_d    = tx_cnt_q;
        tx_done     = 1'b0;
        if (tx_start) begin
            tx_d        = 1'b0;
            tx_active_d = 1'b1;
            tx_shift_d  = {1'b1, ack_q ? ACK_BYTE : NAK_BYTE};
            tx_bit_d    = '0;
            tx_cnt_d    = '0;
        end else if (tx_active_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                // Bit 9 is the stop bit; its end closes the response.
                if (tx_bit_q == 4'd9) begin
                    tx_active_d = 1'b0;
                    tx_done     = 1'b1;
                end else begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    tx_bit_d   = tx_bit_q + 1'b1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q        <= 1'b1;
            tx_active_q <= 1'b0;
            tx_shift_q  <= '1;
            tx_bit_q    <= '0;
            tx_cnt_q    <= '0;
        end else begin
            tx_q        <= tx_d;
            tx_active_q <= tx_active_d;
            tx_shift_q  <= tx_shift_d;
            tx_bit_q    <= tx_bit_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end

    assign tx         = tx_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed frames with random payloads,
// expectations computed from the frame contents by a behavioural model.
module tb_uart_prog_loader;
    localparam int CPB   = 16;
    localparam int WB    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          tx, mem_we, core_rst_n, busy, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .WORD_BYTES  (WB),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .tx        (tx),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst_n(core_rst_n),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        wr_log[$];
    wr_t        exp_wr[$];
    logic [8:0] tx_log[$];
    logic [7:0] frame[$];
    logic [7:0] exp_resp;
    logic       exp_err;
    int         checks = 0;
    int         errors = 0;

    always @(negedge clk) begin
        if (rst_n && mem_we === 1'b1) wr_log.push_back({mem_addr, mem_wdata});
    end

    // Decodes each 8N1 byte on tx, sampling at bit midpoints; stores {stop, data}.
    always begin : tx_mon
        logic [7:0] b;
        @(negedge clk);
        if (rst_n && tx === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            tx_log.push_back({tx, b});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_hdr(input logic [15:0] n);
        frame.delete();
        frame.push_back(8'hA5);
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < WB; k++) frame.push_back(w[8*k +: 8]);
    endtask

    // Reference model: a frame's outcome follows from its length field and payload alone.
    task automatic model_frame();
        int unsigned n;
        logic [31:0] d;
        n = {frame[2], frame[1]};
        exp_wr.delete();
        if (n > DEPTH) begin
            exp_resp = NAK;
            exp_err  = 1'b1;
        end else begin
            exp_resp = ACK;
            exp_err  = 1'b0;
            for (int w = 0; w < int'(n); w++) begin
                d = 32'd0;
                for (int k = 0; k < WB; k++) d = d + (32'(frame[3 + WB*w + k]) << (8*k));
                exp_wr.push_back({AW'(w % DEPTH), d});
            end
        end
    endtask

    task automatic send_frame(input string tag);
        wr_log.delete();
        tx_log.delete();
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i]);
            if (i == 0) begin
                check({tag, "_sync_core_rst"}, 64'(core_rst_n), 64'd0);
                check({tag, "_sync_busy"}, 64'(busy), 64'd1);
                check({tag, "_sync_err"}, 64'(err), 64'd0);
            end
        end
    endtask

    task automatic finish_frame(input string tag);
        int budget;
        int nchk;
        budget = 0;
        while (tx_log.size() == 0 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_resp_seen"}, 64'(tx_log.size() != 0), 64'd1);
        budget = 0;
        while (busy !== 1'b0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        if (tx_log.size() != 0) check({tag, "_resp"}, 64'(tx_log[0]), 64'({1'b1, exp_resp}));
        check({tag, "_resp_count"}, 64'(tx_log.size()), 64'd1);
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        check({tag, "_core_rst"}, 64'(core_rst_n), 64'(exp_resp == ACK));
        check({tag, "_wr_count"}, 64'(wr_log.size()), 64'(exp_wr.size()));
        nchk = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
        for (int i = 0; i < nchk; i++) begin
            check({tag, "_wr_addr"}, 64'(wr_log[i].addr), 64'(exp_wr[i].addr));
            check({tag, "_wr_data"}, 64'(wr_log[i].data), 64'(exp_wr[i].data));
        end
    endtask

    task automatic run_frame(input string tag);
        model_frame();
        send_frame(tag);
        finish_frame(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx"}, 64'(tx), 64'd1);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_core_rst"}, 64'(core_rst_n), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        int unsigned n;
        int unsigned width;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // A non-sync byte in IDLE is ignored
        wr_log.delete();
        tx_log.delete();
        send_byte(8'h55);
        repeat (40) @(negedge clk);
        check("idle55_writes", 64'(wr_log.size()), 64'd0);
        check("idle55_tx", 64'(tx_log.size()), 64'd0);
        check("idle55_busy", 64'(busy), 64'd0);
        check("idle55_core_rst", 64'(core_rst_n), 64'd1);

        // Short low pulse is rejected as a glitch
        width = $urandom_range(1, 5);
        rx = 1'b0;
        repeat (width) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy", 64'(busy), 64'd0);
        check("glitch_core_rst", 64'(core_rst_n), 64'd1);
        check("glitch_tx", 64'(tx_log.size()), 64'd0);

        // Directed two-word load
        push_hdr(16'd2);
        push_word(32'h4433_2211);
        push_word(32'hDDCC_BBAA);
        run_frame("two_word");

        // Zero length and oversize length
        push_hdr(16'd0);
        run_frame("zero_len");
        push_hdr(16'd17);
        run_frame("oversize17");
        push_hdr(16'($urandom_range(18, 65535)));
        run_frame("oversize_rand");

        // Framing error mid-word
        push_hdr(16'd1);
        wr_log.delete();
        tx_log.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'($urandom), 1'b0);
        exp_wr.delete();
        exp_resp = NAK;
        exp_err  = 1'b1;
        finish_frame("frame_err");

        push_hdr(16'd1);
        push_word($urandom);
        run_frame("recover");

        // Random partial load and a full-depth load that wraps the address
        n = $urandom_range(1, DEPTH - 1);
        push_hdr(16'(n));
        for (int w = 0; w < int'(n); w++) push_word($urandom);
        run_frame("rand_load");

        push_hdr(16'(DEPTH));
        for (int w = 0; w < DEPTH; w++) push_word($urandom);
        run_frame("full_load");
        check("full_load_addr_wrap", 64'(mem_addr), 64'd0);

        // Reset in the middle of a load
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        check("midload_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midload_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        push_hdr(16'd2);
        push_word($urandom);
        push_word($urandom);
        run_frame("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
